// File: rtl/button_reader_pkg.sv
// Shared types and helpers for the debounced button event reader.
package button_reader_pkg;

  localparam int MAX_CHAN_W = 3;

  typedef logic [MAX_CHAN_W-1:0] chan_t;

  typedef struct packed {
    chan_t chan;
    logic  press;
  } evt_t;

  typedef struct packed {
    logic valid;
    logic press;
  } slot_t;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int chan_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-FF synchroniser, mismatch counter and accepted stable level.
module button_debounce
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic change,
  output logic new_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  // Strobe fires on the edge where stable takes the synchronised level.
  assign change    = (sync_2 != stable) && (cnt == CNT_LAST);
  assign new_level = sync_2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (change) begin
        cnt    <= '0;
        stable <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_reader.sv
// Debounced button reader: per-channel pending slots feeding a valid/ready event register.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WIDTH-1:0]                   btn_in,
  output logic [WIDTH-1:0]                   btn_state,
  output logic                               evt_valid,
  input  logic                               evt_ready,
  output logic [chan_width(WIDTH)-1:0]       evt_chan,
  output logic                               evt_press,
  output logic                               evt_ovf,
  input  logic                               ovf_clr
);

  localparam int CHAN_W = chan_width(WIDTH);

  logic [WIDTH-1:0] change;
  logic [WIDTH-1:0] new_level;

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw       (btn_in[g]),
      .stable    (btn_state[g]),
      .change    (change[g]),
      .new_level (new_level[g])
    );
  end

  slot_t [WIDTH-1:0] slot_q;
  slot_t [WIDTH-1:0] slot_d;
  evt_t              evt_q;
  logic              any_pending;
  chan_t             sel;
  logic              load_free;
  logic              ovf_set;

  assign load_free = !evt_valid || evt_ready;
  assign evt_chan  = evt_q.chan[CHAN_W-1:0];
  assign evt_press = evt_q.press;

  // Lowest index wins: scan downwards so the last hit is the lowest.
  always_comb begin
    any_pending = 1'b0;
    sel         = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (slot_q[i].valid) begin
        any_pending = 1'b1;
        sel         = chan_t'(i);
      end
    end
  end

  // A slot freed by this edge's load can accept a new event without overflow.
  always_comb begin
    slot_d  = slot_q;
    ovf_set = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      logic cleared;
      cleared = load_free && any_pending && (sel == chan_t'(i));
      if (change[i]) begin
        if (slot_q[i].valid && !cleared) begin
          ovf_set = 1'b1;
        end else begin
          slot_d[i].valid = 1'b1;
          slot_d[i].press = new_level[i];
        end
      end else if (cleared) begin
        slot_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= '0;
      evt_valid <= 1'b0;
      evt_q     <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      if (load_free) begin
        evt_valid <= any_pending;
        if (any_pending) begin
          evt_q.chan  <= sel;
          evt_q.press <= slot_q[sel].press;
        end
      end
      if (ovf_set) begin
        evt_ovf <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf <= 1'b0;
      end
    end
  end

endmodule
